// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and helpers for the multi-cycle shift unit
package shift_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_e;

  function automatic int shamt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic mode_reserved(input logic [2:0] m);
    return m > 3'b100;
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate of one operand by 0..STEP positions
module shift_step
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4,
  parameter int AW   = $clog2(STEP + 1)
) (
  input  logic [N-1:0]  data_in,
  input  logic [AW-1:0] amount,
  input  shift_mode_e   mode,
  output logic [N-1:0]  data_out
);

  int unsigned back;

  // Rotations are built from two logical shifts; amount==0 gives back==N, i.e. 0.
  always_comb begin
    back = N - int'(amount);
    data_out = data_in;
    case (mode)
      SLL:     data_out = data_in << amount;
      SRL:     data_out = data_in >> amount;
      SRA:     data_out = $signed(data_in) >>> amount;
      ROL:     data_out = (data_in << amount) | (data_in >> back);
      ROR:     data_out = (data_in >> amount) | (data_in << back);
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// rtl/shift_unit.sv - variable shift/rotate unit moving at most STEP bits per cycle
module shift_unit
  import shift_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 4,
  parameter int SHW  = shamt_width(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [SHW-1:0] in_shamt,
  input  logic [2:0]     in_mode,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic           out_err
);

  localparam int AW = $clog2(STEP + 1);

  shift_state_e   state;
  shift_mode_e    mode_q;
  logic [N-1:0]   work;
  logic [SHW-1:0] remaining;
  logic [SHW-1:0] rem_next;
  logic [AW-1:0]  step_amt;
  logic [N-1:0]   step_out;
  logic           req_reserved;

  always_comb begin
    step_amt     = (int'(remaining) > STEP) ? AW'(STEP) : AW'(remaining);
    rem_next     = remaining - SHW'(step_amt);
    req_reserved = mode_reserved(in_mode);
  end

  shift_step #(
    .N    (N),
    .STEP (STEP),
    .AW   (AW)
  ) u_step (
    .data_in  (work),
    .amount   (step_amt),
    .mode     (mode_q),
    .data_out (step_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_err   <= 1'b0;
      work      <= '0;
      mode_q    <= SLL;
      remaining <= '0;
    end else if (flush && state != IDLE) begin
      // out_data deliberately keeps the last delivered result
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_err   <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            work     <= in_a;
            mode_q   <= shift_mode_e'(in_mode);
            in_ready <= 1'b0;
            out_err  <= req_reserved;
            if (req_reserved || in_shamt == '0) begin
              remaining <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
              out_data  <= in_a;
            end else begin
              remaining <= in_shamt;
              state     <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work      <= step_out;
          remaining <= rem_next;
          if (rem_next == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= step_out;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit.sv
// tb/tb_shift_unit.sv - directed self-checking bench for shift_unit (N=32, STEP=4)
module tb_shift_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic [2:0]  in_mode;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_err;

  int checks   = 0;
  int failures = 0;
  int cycles;
  logic seen_valid;

  shift_unit #(.N(32), .STEP(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .in_mode   (in_mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request, wait for the result, then confirm return to IDLE (out_ready held 1).
  task automatic run_op(input string tag, input logic [2:0] mode, input logic [31:0] a,
                        input logic [4:0] shamt, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat);
    in_valid = 1'b1; in_a = a; in_shamt = shamt; in_mode = mode;
    tick();
    in_valid = 1'b0; in_a = ~a; in_shamt = 5'd17; in_mode = 3'b000;
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    check({tag, "_lat"}, cycles, exp_lat);
    check({tag, "_data"}, out_data, exp_data);
    check({tag, "_err"}, {31'd0, out_err}, {31'd0, exp_err});
    tick();
    check({tag, "_idle"}, {30'd0, in_ready, out_valid}, 32'd2);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_shamt = '0; in_mode = '0;
    flush = 1'b0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    run_op("sll2",  3'b000, 32'h0000_0001, 5'd2,  32'h0000_0004, 1'b0, 2);
    run_op("sra31", 3'b010, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 9);
    run_op("srl31", 3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 1'b0, 9);
    run_op("ror4",  3'b100, 32'h0000_00F1, 5'd4,  32'h1000_000F, 1'b0, 2);
    run_op("rol1",  3'b011, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 2);
    run_op("rol0",  3'b011, 32'h1234_5678, 5'd0,  32'h1234_5678, 1'b0, 1);
    run_op("rsvd",  3'b111, 32'h1234_5678, 5'd5,  32'h1234_5678, 1'b1, 1);
    run_op("rol8",  3'b011, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 3);
    run_op("sra7p", 3'b010, 32'h7000_0000, 5'd7,  32'h00E0_0000, 1'b0, 3);
    run_op("ror31", 3'b100, 32'h1234_5678, 5'd31, 32'h2468_ACF0, 1'b0, 9);

    // Backpressure: result must hold while a competing request is refused.
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 32'h1; in_shamt = 5'd5; in_mode = 3'b000;
    tick();
    in_a = 32'hDEAD_BEEF; in_shamt = 5'd3; in_mode = 3'b001;
    cycles = 1;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    check("bp_lat", cycles, 3);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_data", out_data, 32'h20);
      check("bp_hold_flags", {29'd0, out_valid, in_ready, out_err}, 32'b100);
      tick();
    end
    in_a = 32'h55; in_shamt = 5'd0; in_mode = 3'b000;
    out_ready = 1'b1;
    tick();
    check("bp_release", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    in_valid = 1'b0;
    check("bp_next_valid", {31'd0, out_valid}, 32'd1);
    check("bp_next_data", out_data, 32'h55);
    tick();

    // flush during SHIFT
    in_valid = 1'b1; in_a = 32'h1; in_shamt = 5'd20; in_mode = 3'b000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_state", {30'd0, in_ready, out_valid}, 32'd2);
    check("flush_data", out_data, 32'h55);
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      seen_valid = seen_valid | out_valid;
      tick();
    end
    check("flush_no_valid", {31'd0, seen_valid}, 32'd0);

    // flush with a request in IDLE: request dropped
    flush = 1'b1; in_valid = 1'b1; in_a = 32'h77; in_shamt = 5'd0;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", {30'd0, in_ready, out_valid}, 32'd2);
    tick();
    check("flush_idle_after", {31'd0, out_valid}, 32'd0);

    // async reset mid-SHIFT
    run_op("pre_rst", 3'b111, 32'hCAFE_0001, 5'd0, 32'hCAFE_0001, 1'b1, 1);
    in_valid = 1'b1; in_a = 32'h8000_0000; in_shamt = 5'd31; in_mode = 3'b010;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #2;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", out_data, 32'd0);
    check("arst_out_err", {31'd0, out_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op("post_rst", 3'b000, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFF0, 1'b0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
